// File: rtl/goofy_alu_seq.sv
// goofy_alu_seq: byte-code sequencer driving an external ALU.
// Fetches opcodes and operand bytes over a ready/valid style memory port,
// loads ALU operand registers, fires one op strobe, waits ALU_LAT clocks and
// captures the ALU result. Supports a conditional jump on the ALU equal flag,
// and halts on HLT, an illegal opcode (sticky err), or the ALU halt flag.
// Ports:
//   clk, res                  clock, asynchronous active-low reset
//   mem_addr/mem_rd           fetch address and read request (held until ready)
//   mem_rdata/mem_ready       read data and read-data-valid
//   ali0w/alu0d, ali1w/alu1d  ALU operand register write strobes and data
//   alu_add .. alu_flag_res   single-cycle ALU op strobes
//   alu_out, alu_flag_eq/hlt  ALU result and flags
//   result/result_valid       last captured ALU result and its 1-cycle pulse
//   pc, halted, err           program counter, halt indicator, sticky error
module goofy_alu_seq #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         ALU_LAT  = 2
) (
    input  logic       clk,
    input  logic       res,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       ali0w,
    output logic [7:0] alu0d,
    output logic       ali1w,
    output logic [7:0] alu1d,
    output logic       alu_add,
    output logic       alu_add_ov,
    output logic       alu_sub,
    output logic       alu_sub_ov,
    output logic       alu_and,
    output logic       alu_or,
    output logic       alu_not,
    output logic       alu_cmp,
    output logic       alu_hlt,
    output logic       alu_flag_res,
    input  logic [7:0] alu_out,
    input  logic       alu_flag_eq,
    input  logic       alu_flag_hlt,
    output logic [7:0] result,
    output logic       result_valid,
    output logic [7:0] pc,
    output logic       halted,
    output logic       err
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_OPA    = 4'd2;
    localparam logic [3:0] S_OPB    = 4'd3;
    localparam logic [3:0] S_LOAD   = 4'd4;
    localparam logic [3:0] S_EXEC   = 4'd5;
    localparam logic [3:0] S_WAIT   = 4'd6;
    localparam logic [3:0] S_WB     = 4'd7;
    localparam logic [3:0] S_JMP    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADC  = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_SBC  = 8'h04;
    localparam logic [7:0] OP_AND  = 8'h05;
    localparam logic [7:0] OP_OR   = 8'h06;
    localparam logic [7:0] OP_NOT  = 8'h07;
    localparam logic [7:0] OP_CMP  = 8'h08;
    localparam logic [7:0] OP_JEQ  = 8'h09;
    localparam logic [7:0] OP_CLRF = 8'h0A;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    // Last WAIT count value; WAIT lasts ALU_LAT cycles (counter 0..ALU_LAT-1).
    localparam logic [2:0] LAT_LAST = 3'(ALU_LAT - 1);

    // Strobe vector order: add, add_ov, sub, sub_ov, and, or, not, cmp, hlt, flag_res.
    function automatic logic [9:0] op_strobe(input logic [7:0] op);
        case (op)
            OP_ADD:  op_strobe = 10'b10_0000_0000;
            OP_ADC:  op_strobe = 10'b01_0000_0000;
            OP_SUB:  op_strobe = 10'b00_1000_0000;
            OP_SBC:  op_strobe = 10'b00_0100_0000;
            OP_AND:  op_strobe = 10'b00_0010_0000;
            OP_OR:   op_strobe = 10'b00_0001_0000;
            OP_NOT:  op_strobe = 10'b00_0000_1000;
            OP_CMP:  op_strobe = 10'b00_0000_0100;
            OP_HLT:  op_strobe = 10'b00_0000_0010;
            OP_CLRF: op_strobe = 10'b00_0000_0001;
            default: op_strobe = 10'b00_0000_0000;
        endcase
    endfunction

    function automatic logic two_op(input logic [7:0] op);
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_CMP: two_op = 1'b1;
            default: two_op = 1'b0;
        endcase
    endfunction

    logic [3:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       rd_q, rd_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       err_q, err_d;
    logic       ali0w_q, ali0w_d, ali1w_q, ali1w_d;
    logic [7:0] alu0d_q, alu0d_d, alu1d_q, alu1d_d;
    logic [9:0] strobe_q, strobe_d;
    logic       rv_q, rv_d;
    logic       halted_q, halted_d;
    logic       is_rd_state_s;
    logic       rd_done_s;

    assign is_rd_state_s = (state_q == S_FETCH) || (state_q == S_OPA) ||
                           (state_q == S_OPB)   || (state_q == S_JMP);

    // Next-state, memory handshake and datapath capture.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        rd_done_s = 1'b0;
        // A read raises mem_rd one cycle, then waits for mem_ready with the
        // address held; completion drops mem_rd and bumps pc (8-bit wrap).
        if (is_rd_state_s) begin
            if (!rd_q) begin
                rd_d = 1'b1;
            end else if (mem_ready) begin
                rd_d      = 1'b0;
                pc_d      = pc_q + 8'd1;
                rd_done_s = 1'b1;
            end else begin
                rd_d = rd_q;
            end
        end else begin
            rd_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (alu_flag_hlt) begin
                    state_d = S_HALT;
                    rd_d    = 1'b0;
                    pc_d    = pc_q;
                end else if (rd_done_s) begin
                    opcode_d = mem_rdata;
                    state_d  = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_q)
                    OP_NOP: state_d = S_FETCH;
                    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_NOT, OP_CMP:
                        state_d = S_OPA;
                    OP_JEQ: state_d = S_JMP;
                    OP_CLRF, OP_HLT: state_d = S_EXEC;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_OPA: begin
                if (rd_done_s) begin
                    opa_d   = mem_rdata;
                    state_d = (opcode_q == OP_NOT) ? S_LOAD : S_OPB;
                end else begin
                    state_d = S_OPA;
                end
            end
            S_OPB: begin
                if (rd_done_s) begin
                    opb_d   = mem_rdata;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_OPB;
                end
            end
            S_LOAD: state_d = S_EXEC;
            S_EXEC: begin
                cnt_d = 3'd0;
                case (opcode_q)
                    OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_NOT, OP_CMP:
                        state_d = S_WAIT;
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    // CMP only updates ALU flags, so it skips write-back.
                    if (opcode_q == OP_CMP) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d  = S_WB;
                        result_d = alu_out;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB: state_d = S_FETCH;
            S_JMP: begin
                if (rd_done_s) begin
                    state_d = S_FETCH;
                    if (alu_flag_eq) begin
                        pc_d = mem_rdata;
                    end else begin
                        pc_d = pc_q + 8'd1;
                    end
                end else begin
                    state_d = S_JMP;
                end
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end
        endcase
    end

    // Output register next values, derived from the upcoming state so each
    // registered strobe is high exactly while the FSM sits in LOAD/EXEC/WB/HALT.
    always_comb begin
        ali0w_d  = (state_d == S_LOAD);
        ali1w_d  = (state_d == S_LOAD) && two_op(opcode_q);
        alu0d_d  = ali0w_d ? opa_d : alu0d_q;
        alu1d_d  = ali1w_d ? opb_d : alu1d_q;
        strobe_d = (state_d == S_EXEC) ? op_strobe(opcode_q) : 10'd0;
        rv_d     = (state_d == S_WB);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            rd_q     <= 1'b0;
            opcode_q <= 8'h00;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            cnt_q    <= 3'd0;
            result_q <= 8'h00;
            err_q    <= 1'b0;
            ali0w_q  <= 1'b0;
            ali1w_q  <= 1'b0;
            alu0d_q  <= 8'h00;
            alu1d_q  <= 8'h00;
            strobe_q <= 10'd0;
            rv_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
            ali0w_q  <= ali0w_d;
            ali1w_q  <= ali1w_d;
            alu0d_q  <= alu0d_d;
            alu1d_q  <= alu1d_d;
            strobe_q <= strobe_d;
            rv_q     <= rv_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr     = pc_q;
    assign pc           = pc_q;
    assign mem_rd       = rd_q;
    assign ali0w        = ali0w_q;
    assign ali1w        = ali1w_q;
    assign alu0d        = alu0d_q;
    assign alu1d        = alu1d_q;
    assign alu_add      = strobe_q[9];
    assign alu_add_ov   = strobe_q[8];
    assign alu_sub      = strobe_q[7];
    assign alu_sub_ov   = strobe_q[6];
    assign alu_and      = strobe_q[5];
    assign alu_or       = strobe_q[4];
    assign alu_not      = strobe_q[3];
    assign alu_cmp      = strobe_q[2];
    assign alu_hlt      = strobe_q[1];
    assign alu_flag_res = strobe_q[0];
    assign result       = result_q;
    assign result_valid = rv_q;
    assign halted       = halted_q;
    assign err          = err_q;

endmodule

// File: tb/tb_goofy_alu_seq.sv
// Self-checking bench for goofy_alu_seq: table of single-op programs plus
// hand-written sequences for wait states, jumps, halts, wrap and mid-read reset.
module tb_goofy_alu_seq;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [7:0] mem [256];
    logic [3:0] wcnt;
    int         rd_delay = 0;
    logic       ready_always = 1'b0;

    logic [7:0] mem_addr, mem_rdata, alu0d, alu1d, result, pc;
    logic       mem_rd, mem_ready, ali0w, ali1w, result_valid, halted, err;
    logic       alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and, alu_or;
    logic       alu_not, alu_cmp, alu_hlt, alu_flag_res;
    logic [7:0] alu_out = 8'h00;
    logic       alu_flag_eq = 1'b0;
    logic       alu_flag_hlt = 1'b0;

    logic [7:0] m2_addr, m2_rdata, alu0d_2, alu1d_2, result_2, pc_2;
    logic       m2_rd, m2_ready, ali0w_2, ali1w_2, result_valid_2, halted_2, err_2;
    logic [9:0] strobes_2;

    logic [9:0] strobes;
    assign strobes = {alu_add, alu_add_ov, alu_sub, alu_sub_ov, alu_and,
                      alu_or, alu_not, alu_cmp, alu_hlt, alu_flag_res};

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = ready_always | (mem_rd & (32'(wcnt) >= rd_delay));
    assign m2_rdata  = mem[m2_addr];
    assign m2_ready  = m2_rd;

    goofy_alu_seq #(.RESET_PC(8'h00), .ALU_LAT(LAT)) u_dut (
        .clk(clk), .res(res), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ali0w(ali0w), .alu0d(alu0d), .ali1w(ali1w), .alu1d(alu1d),
        .alu_add(alu_add), .alu_add_ov(alu_add_ov), .alu_sub(alu_sub),
        .alu_sub_ov(alu_sub_ov), .alu_and(alu_and), .alu_or(alu_or),
        .alu_not(alu_not), .alu_cmp(alu_cmp), .alu_hlt(alu_hlt),
        .alu_flag_res(alu_flag_res), .alu_out(alu_out),
        .alu_flag_eq(alu_flag_eq), .alu_flag_hlt(alu_flag_hlt),
        .result(result), .result_valid(result_valid), .pc(pc),
        .halted(halted), .err(err)
    );

    goofy_alu_seq #(.RESET_PC(8'hFF), .ALU_LAT(LAT)) u_dut_ff (
        .clk(clk), .res(res), .mem_addr(m2_addr), .mem_rd(m2_rd),
        .mem_rdata(m2_rdata), .mem_ready(m2_ready),
        .ali0w(ali0w_2), .alu0d(alu0d_2), .ali1w(ali1w_2), .alu1d(alu1d_2),
        .alu_add(strobes_2[9]), .alu_add_ov(strobes_2[8]), .alu_sub(strobes_2[7]),
        .alu_sub_ov(strobes_2[6]), .alu_and(strobes_2[5]), .alu_or(strobes_2[4]),
        .alu_not(strobes_2[3]), .alu_cmp(strobes_2[2]), .alu_hlt(strobes_2[1]),
        .alu_flag_res(strobes_2[0]), .alu_out(alu_out),
        .alu_flag_eq(alu_flag_eq), .alu_flag_hlt(alu_flag_hlt),
        .result(result_2), .result_valid(result_valid_2), .pc(pc_2),
        .halted(halted_2), .err(err_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory wait-state counter: mem_ready rises rd_delay cycles into a read.
    always @(posedge clk or negedge res) begin
        if (!res) wcnt <= 4'd0;
        else if (!mem_rd) wcnt <= 4'd0;
        else if (wcnt != 4'hF) wcnt <= wcnt + 4'd1;
    end

    // Per-test observations (cleared by reset) and global protocol counters.
    logic [9:0] strobe_seen;
    int         strobe_cyc, rv_cnt, rd_cnt;
    logic       a_seen, b_seen, prev_rd, prev_ready;
    logic [7:0] a_val = 8'h00, b_val = 8'h00, prev_addr;
    int         multi_hot = 0, unstable = 0, rd_not_low = 0, halt_leak = 0;

    // Monitor and ALU model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!res) begin
            strobe_seen = 10'd0; strobe_cyc = -1; rv_cnt = 0; rd_cnt = 0;
            a_seen = 1'b0; b_seen = 1'b0; prev_rd = 1'b0; prev_ready = 1'b0;
            prev_addr = 8'h00;
        end else begin
            if ($countones(strobes) > 1) multi_hot++;
            if ((ali0w || ali1w) && strobes != 10'd0) multi_hot++;
            if (mem_rd && prev_rd && !prev_ready && mem_addr != prev_addr) unstable++;
            if (mem_rd && prev_rd && prev_ready) rd_not_low++;
            if (halted && (strobes != 10'd0 || mem_rd || ali0w || ali1w)) halt_leak++;
            prev_rd = mem_rd; prev_ready = mem_ready; prev_addr = mem_addr;
            if (mem_rd) rd_cnt++;
            if (ali0w) begin a_seen = 1'b1; a_val = alu0d; end
            if (ali1w) begin b_seen = 1'b1; b_val = alu1d; end
            if (strobes != 10'd0) begin
                strobe_seen |= strobes;
                strobe_cyc = cyc;
                if (alu_add)         alu_out = a_val + b_val;
                else if (alu_add_ov) alu_out = a_val + b_val + 8'd1;
                else if (alu_sub)    alu_out = a_val - b_val;
                else if (alu_sub_ov) alu_out = a_val - b_val - 8'd1;
                else if (alu_and)    alu_out = a_val & b_val;
                else if (alu_or)     alu_out = a_val | b_val;
                else if (alu_not)    alu_out = ~a_val;
                else                 alu_out = alu_out;
            end
            if (result_valid) rv_cnt++;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        res = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic wait_rv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (result_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mem_rd) begin ok = 1'b1; break; end
        end
    endtask

    typedef struct {
        logic [7:0] op, a, b;
        logic       two;
        logic [9:0] strobe;
        logic [7:0] res, pc;
    } vec_t;

    vec_t vt [7];
    bit   ok;
    int   rb;

    initial begin
        // opcode, A, B, two-operand, expected strobe, expected result, pc at WB
        vt[0] = '{8'h01, 8'h05, 8'h07, 1'b1, 10'b10_0000_0000, 8'h0C, 8'h03};
        vt[1] = '{8'h02, 8'h10, 8'h20, 1'b1, 10'b01_0000_0000, 8'h31, 8'h03};
        vt[2] = '{8'h03, 8'h50, 8'h13, 1'b1, 10'b00_1000_0000, 8'h3D, 8'h03};
        vt[3] = '{8'h04, 8'h03, 8'h05, 1'b1, 10'b00_0100_0000, 8'hFD, 8'h03};
        vt[4] = '{8'h05, 8'hF0, 8'h3C, 1'b1, 10'b00_0010_0000, 8'h30, 8'h03};
        vt[5] = '{8'h06, 8'hF0, 8'h0F, 1'b1, 10'b00_0001_0000, 8'hFF, 8'h03};
        vt[6] = '{8'h07, 8'h5A, 8'h00, 1'b0, 10'b00_0000_1000, 8'hA5, 8'h02};

        // Reset values of both instances, then RESET_PC=FF wrap on the second.
        mem_clear();
        #2 res = 1'b0;
        #1;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_pc", pc, 8'h00);
        chk("rst_outs", {ali0w, ali1w, alu0d, alu1d, strobes, result, result_valid, halted, err}, 0);
        chk("rst_ff_addr", m2_addr, 8'hFF);
        chk("rst_ff_pc", pc_2, 8'hFF);
        @(negedge clk); @(negedge clk);
        res = 1'b1;
        @(posedge clk); #1;
        chk("first_rd_after_rst", mem_rd, 1);
        chk("wrap_first_addr", m2_addr, 8'hFF);
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m2_rd) begin ok = 1'b1; break; end
        end
        chk("wrap_second_rd_seen", ok, 1);
        chk("wrap_second_addr", m2_addr, 8'h00);

        // Table of single-op programs with zero-wait memory.
        for (int v = 0; v < 7; v++) begin
            mem_clear();
            mem[0] = vt[v].op; mem[1] = vt[v].a;
            if (vt[v].two) mem[2] = vt[v].b;
            do_reset();
            wait_rv(ok);
            chk("vec_rv_seen", ok, 1);
            chk("vec_result", result, vt[v].res);
            chk("vec_pc", pc, vt[v].pc);
            chk("vec_strobe", strobe_seen, vt[v].strobe);
            chk("vec_latency", cyc - strobe_cyc, LAT + 1);
            chk("vec_opA", {a_seen, a_val}, {1'b1, vt[v].a});
            if (vt[v].two) chk("vec_opB", {b_seen, b_val}, {1'b1, vt[v].b});
            else           chk("vec_no_ali1w", b_seen, 0);
            repeat (2) @(negedge clk);
            chk("vec_rv_pulses", rv_cnt, 1);
        end

        // ADD with 3 wait states per read.
        mem_clear();
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h07;
        rd_delay = 3;
        do_reset();
        wait_rv(ok);
        chk("slow_rv_seen", ok, 1);
        chk("slow_result", result, 8'h0C);
        chk("slow_latency", cyc - strobe_cyc, LAT + 1);
        wait_rd(ok);
        chk("slow_next_fetch_seen", ok, 1);
        chk("slow_next_fetch_addr", mem_addr, 8'h03);
        chk("slow_addr_stable", unstable, 0);
        rd_delay = 0;

        // CMP then JEQ, taken and not taken (not taken with mem_ready tied high).
        for (int e = 0; e < 2; e++) begin
            mem_clear();
            mem[0] = 8'h08; mem[1] = 8'hAA; mem[2] = 8'hAA; mem[3] = 8'h09; mem[4] = 8'h40;
            alu_flag_eq  = (e == 1);
            ready_always = (e == 0);
            do_reset();
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (mem_rd && mem_ready && mem_addr == 8'h04) begin ok = 1'b1; break; end
            end
            chk("jeq_target_read", ok, 1);
            wait_rd(ok);
            chk("jeq_next_fetch_seen", ok, 1);
            chk("jeq_next_fetch_addr", mem_addr, (e == 1) ? 8'h40 : 8'h05);
            chk("cmp_strobe", strobe_seen, 10'b00_0000_0100);
            chk("cmp_no_rv", rv_cnt, 0);
        end
        alu_flag_eq = 1'b0;
        ready_always = 1'b0;

        // Illegal opcode: halt with sticky err, no further reads.
        mem_clear();
        mem[0] = 8'h33;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
        chk("ill_halted", ok, 1);
        rb = rd_cnt;
        repeat (20) @(negedge clk);
        chk("ill_err", err, 1);
        chk("ill_still_halted", halted, 1);
        chk("ill_no_rd", rd_cnt, rb);
        chk("ill_no_strobes", strobe_seen, 0);
        res = 1'b0;
        #1;
        chk("ill_rst_clears", {err, halted}, 2'b00);

        // CLRF then HLT.
        mem_clear();
        mem[0] = 8'h0A; mem[1] = 8'hFF;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (halted) begin ok = 1'b1; break; end
        end
        chk("hlt_halted", ok, 1);
        chk("hlt_strobes", strobe_seen, 10'b00_0000_0011);
        chk("hlt_no_err", err, 0);
        chk("hlt_no_rv", rv_cnt, 0);
        chk("hlt_pc", pc, 8'h02);

        // ALU halt flag in FETCH: halt before any read.
        mem_clear();
        alu_flag_hlt = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        chk("flaghlt_halted", halted, 1);
        chk("flaghlt_no_rd", rd_cnt, 0);
        alu_flag_hlt = 1'b0;

        // Reset while the second ADD waits on its OPB read.
        mem_clear();
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h07;
        mem[3] = 8'h01; mem[4] = 8'h05; mem[5] = 8'h07;
        rd_delay = 3;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_rd && mem_addr == 8'h05) begin ok = 1'b1; break; end
        end
        chk("midrst_opb_wait_seen", ok, 1);
        chk("midrst_prior_result", result, 8'h0C);
        @(negedge clk);
        #2 res = 1'b0;
        #1;
        chk("midrst_mem_rd", mem_rd, 0);
        chk("midrst_addr_pc", {mem_addr, pc}, 16'h0000);
        chk("midrst_operands", {alu0d, alu1d}, 16'h0000);
        chk("midrst_result", {result, result_valid}, 9'h000);
        chk("midrst_strobes", {strobes, ali0w, ali1w, halted, err}, 0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk); #1;
        chk("midrst_restart_rd", mem_rd, 1);
        chk("midrst_restart_addr", mem_addr, 8'h00);
        rd_delay = 0;
        repeat (3) @(negedge clk);

        chk("one_hot_strobes", multi_hot, 0);
        chk("addr_stable_all", unstable, 0);
        chk("rd_low_after_ready", rd_not_low, 0);
        chk("halt_quiet", halt_leak, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
